// File: rtl/xg_pon_sync_controller.sv
// XG-PON downstream frame delineation: HUNT/PRESYNC/SYNC with flywheel frame counter.
// Optional HUNT watchdog built when XG_PON_SYNC_HUNT_TIMEOUT_EN is defined.
module xg_pon_sync_controller #(
  parameter int unsigned FRAME_WORDS = 38880,
  parameter int unsigned M1          = 2,
  parameter int unsigned M2          = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             valid_in,
  input  logic             det_in,
  input  logic             resync_in,
  input  logic [6:0]       cfg_hunt_thr_in,
  input  logic [6:0]       cfg_sync_thr_in,
  output logic [6:0]       threshold_out,
  output logic             sync_reset_out,
  output logic [1:0]       state_out,
  output logic             in_sync_out,
  output logic             frame_start_out,
  output logic [CNT_W-1:0] frame_count_out,
  output logic [CNT_W-1:0] lof_count_out,
  output logic             hunt_timeout_out
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PRESYNC = 2'd1,
    ST_SYNC    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] M1_C     = CNT_W'(M1);
  localparam logic [CNT_W-1:0] M2_C     = CNT_W'(M2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] lof_count_q, lof_count_d;
  logic             sync_reset_q, sync_reset_d;
  logic             frame_start_q, frame_start_d;
  logic             boundary_c;
  logic [CNT_W-1:0] good_inc_c, miss_inc_c;

`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
  localparam int unsigned    WD_W    = $clog2(4 * FRAME_WORDS);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(4 * FRAME_WORDS - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            hunt_timeout_q, hunt_timeout_d;
`endif

  // Next-state and registered-output logic; resync_in outranks every frame event
  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    good_d        = good_q;
    miss_d        = miss_q;
    frame_count_d = frame_count_q;
    lof_count_d   = lof_count_q;
    sync_reset_d  = 1'b0;
    frame_start_d = 1'b0;
    boundary_c    = valid_in && (pos_q == LAST_POS);
    good_inc_c    = good_q + CNT_W'(1);
    miss_inc_c    = miss_q + CNT_W'(1);

    if (resync_in) begin
      state_d      = ST_HUNT;
      sync_reset_d = 1'b1;
      pos_d        = '0;
      good_d       = '0;
      miss_d       = '0;
    end else if (valid_in) begin
      unique case (state_q)
        ST_HUNT: begin
          if (det_in) begin
            pos_d   = '0;
            good_d  = CNT_W'(1);
            miss_d  = '0;
            state_d = (M1_C == CNT_W'(1)) ? ST_SYNC : ST_PRESYNC;
          end
        end
        ST_PRESYNC: begin
          if (boundary_c) begin
            pos_d = '0;
            if (det_in) begin
              good_d = good_inc_c;
              if (good_inc_c == M1_C) begin
                state_d       = ST_SYNC;
                frame_start_d = 1'b1;
                frame_count_d = frame_count_q + CNT_W'(1);
                miss_d        = '0;
              end
            end else begin
              state_d      = ST_HUNT;
              sync_reset_d = 1'b1;
              good_d       = '0;
            end
          end else begin
            pos_d = pos_q + CNT_W'(1);
          end
        end
        ST_SYNC: begin
          if (boundary_c) begin
            pos_d = '0;
            if (det_in) begin
              miss_d        = '0;
              frame_start_d = 1'b1;
              frame_count_d = frame_count_q + CNT_W'(1);
            end else if (miss_inc_c == M2_C) begin
              state_d      = ST_HUNT;
              sync_reset_d = 1'b1;
              miss_d       = '0;
              good_d       = '0;
              if (lof_count_q != '1) lof_count_d = lof_count_q + CNT_W'(1);
            end else begin
              miss_d        = miss_inc_c;
              frame_start_d = 1'b1;
              frame_count_d = frame_count_q + CNT_W'(1);
            end
          end else begin
            pos_d = pos_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
    // Watchdog only advances on valid words that leave the FSM in HUNT
    wd_d           = wd_q;
    hunt_timeout_d = 1'b0;
    if (resync_in || (state_q != ST_HUNT) || (valid_in && (state_d != ST_HUNT))) begin
      wd_d = '0;
    end else if (valid_in) begin
      if (wd_q == WD_LAST) begin
        wd_d           = '0;
        hunt_timeout_d = 1'b1;
        sync_reset_d   = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q        <= ST_HUNT;
      pos_q          <= '0;
      good_q         <= '0;
      miss_q         <= '0;
      frame_count_q  <= '0;
      lof_count_q    <= '0;
      sync_reset_q   <= 1'b0;
      frame_start_q  <= 1'b0;
`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
      wd_q           <= '0;
      hunt_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      good_q         <= good_d;
      miss_q         <= miss_d;
      frame_count_q  <= frame_count_d;
      lof_count_q    <= lof_count_d;
      sync_reset_q   <= sync_reset_d;
      frame_start_q  <= frame_start_d;
`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
      wd_q           <= wd_d;
      hunt_timeout_q <= hunt_timeout_d;
`endif
    end
  end

  assign threshold_out   = (state_q == ST_HUNT) ? cfg_hunt_thr_in : cfg_sync_thr_in;
  assign sync_reset_out  = sync_reset_q;
  assign state_out       = state_q;
  assign in_sync_out     = (state_q == ST_SYNC);
  assign frame_start_out = frame_start_q;
  assign frame_count_out = frame_count_q;
  assign lof_count_out   = lof_count_q;
`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
  assign hunt_timeout_out = hunt_timeout_q;
`else
  assign hunt_timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_xg_pon_sync_controller.sv
// Self-checking bench for xg_pon_sync_controller: vector table through a scoreboard queue,
// plus a hand-written reset-over-resync sequence. FRAME_WORDS=16, M1=2, M2=3.
module tb_xg_pon_sync_controller;

  localparam int unsigned FW    = 16;
  localparam int unsigned M1    = 2;
  localparam int unsigned M2    = 3;
  localparam int unsigned CNT_W = 16;
  localparam logic [6:0]  HUNT_THR = 7'h11;
  localparam logic [6:0]  SYNC_THR = 7'h2A;

  logic             clk_in = 1'b0;
  logic             reset_in = 1'b1;
  logic             valid_in = 1'b0;
  logic             det_in = 1'b0;
  logic             resync_in = 1'b0;
  logic [6:0]       cfg_hunt_thr_in = HUNT_THR;
  logic [6:0]       cfg_sync_thr_in = SYNC_THR;
  logic [6:0]       threshold_out;
  logic             sync_reset_out;
  logic [1:0]       state_out;
  logic             in_sync_out;
  logic             frame_start_out;
  logic [CNT_W-1:0] frame_count_out;
  logic [CNT_W-1:0] lof_count_out;
  logic             hunt_timeout_out;

  xg_pon_sync_controller #(
    .FRAME_WORDS(FW), .M1(M1), .M2(M2), .CNT_W(CNT_W)
  ) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .valid_in        (valid_in),
    .det_in          (det_in),
    .resync_in       (resync_in),
    .cfg_hunt_thr_in (cfg_hunt_thr_in),
    .cfg_sync_thr_in (cfg_sync_thr_in),
    .threshold_out   (threshold_out),
    .sync_reset_out  (sync_reset_out),
    .state_out       (state_out),
    .in_sync_out     (in_sync_out),
    .frame_start_out (frame_start_out),
    .frame_count_out (frame_count_out),
    .lof_count_out   (lof_count_out),
    .hunt_timeout_out(hunt_timeout_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic rst, valid, det, resync;
    int   rep;
    int   st, fs, sr, ht, fc, lof;
  } vec_t;

  typedef struct {
    int row, rep;
    int st, fs, sr, ht, fc, lof;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t v(input logic rst, valid, det, resync, input int rep,
                             input int st, fs, sr, ht, fc, lof);
    vec_t r;
    r.rst = rst; r.valid = valid; r.det = det; r.resync = resync; r.rep = rep;
    r.st = st; r.fs = fs; r.sr = sr; r.ht = ht; r.fc = fc; r.lof = lof;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input int rep, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s row %0d rep %0d: actual %0d required %0d", name, row, rep, act, req);
  endtask

  // Drive one word, queue its expectation, then compare once the edge has produced the output
  task automatic step(input logic rst, valid, det, resync, input exp_t e);
    exp_t got;
    reset_in = rst; valid_in = valid; det_in = det; resync_in = resync;
    sb.push_back(e);
    @(posedge clk_in);
    #1;
    got = sb.pop_front();
    chk("state",       got.row, got.rep, int'(state_out),        got.st);
    chk("in_sync",     got.row, got.rep, int'(in_sync_out),      (got.st == 2) ? 1 : 0);
    chk("threshold",   got.row, got.rep, int'(threshold_out),    (got.st == 0) ? int'(HUNT_THR) : int'(SYNC_THR));
    chk("frame_start", got.row, got.rep, int'(frame_start_out),  got.fs);
    chk("sync_reset",  got.row, got.rep, int'(sync_reset_out),   got.sr);
    chk("hunt_timeout",got.row, got.rep, int'(hunt_timeout_out), got.ht);
    chk("frame_count", got.row, got.rep, int'(frame_count_out),  got.fc);
    chk("lof_count",   got.row, got.rep, int'(lof_count_out),    got.lof);
  endtask

  function automatic exp_t mk(input int row, rep, st, fs, sr, ht, fc, lof);
    exp_t e;
    e.row = row; e.rep = rep; e.st = st; e.fs = fs; e.sr = sr; e.ht = ht; e.fc = fc; e.lof = lof;
    return e;
  endfunction

  initial begin
    // reset: HUNT, counters 0, hunt threshold
    vecs.push_back(v(1,0,0,0, 2,  0,0,0,0, 0,0));
    // acquisition: det on word 0 and word 16
    vecs.push_back(v(0,1,1,0, 1,  1,0,0,0, 0,0));
    vecs.push_back(v(0,1,0,0,15,  1,0,0,0, 0,0));
    vecs.push_back(v(0,1,1,0, 1,  2,1,0,0, 1,0));
    // flywheel: two missing boundaries, then a detected one
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 1,0));
    vecs.push_back(v(0,1,0,0, 1,  2,1,0,0, 2,0));
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 2,0));
    vecs.push_back(v(0,1,0,0, 1,  2,1,0,0, 3,0));
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 3,0));
    vecs.push_back(v(0,1,1,0, 1,  2,1,0,0, 4,0));
    // loss of frame: three missing boundaries
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 4,0));
    vecs.push_back(v(0,1,0,0, 1,  2,1,0,0, 5,0));
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 5,0));
    vecs.push_back(v(0,1,0,0, 1,  2,1,0,0, 6,0));
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 6,0));
    vecs.push_back(v(0,1,0,0, 1,  0,0,1,0, 6,1));
    // false detect in PRESYNC and a 7-cycle valid gap
    vecs.push_back(v(0,1,1,0, 1,  1,0,0,0, 6,1));
    vecs.push_back(v(0,1,0,0, 4,  1,0,0,0, 6,1));
    vecs.push_back(v(0,1,1,0, 1,  1,0,0,0, 6,1));
    vecs.push_back(v(0,0,1,0, 7,  1,0,0,0, 6,1));
    vecs.push_back(v(0,1,0,0,10,  1,0,0,0, 6,1));
    vecs.push_back(v(0,1,1,0, 1,  2,1,0,0, 7,1));
    // resync on a boundary det in SYNC
    vecs.push_back(v(0,1,0,0,15,  2,0,0,0, 7,1));
    vecs.push_back(v(0,1,1,1, 1,  0,0,1,0, 7,1));
    // PRESYNC boundary miss: back to HUNT without LOF
    vecs.push_back(v(0,1,1,0, 1,  1,0,0,0, 7,1));
    vecs.push_back(v(0,1,0,0,15,  1,0,0,0, 7,1));
    vecs.push_back(v(0,1,0,0, 1,  0,0,1,0, 7,1));
    // det with valid low is ignored in HUNT
    vecs.push_back(v(0,0,1,0, 3,  0,0,0,0, 7,1));
    // HUNT watchdog: 64 valid words without det
`ifdef XG_PON_SYNC_HUNT_TIMEOUT_EN
    vecs.push_back(v(0,1,0,0,63,  0,0,0,0, 7,1));
    vecs.push_back(v(0,1,0,0, 1,  0,0,1,1, 7,1));
    vecs.push_back(v(0,1,0,0, 5,  0,0,0,0, 7,1));
`else
    vecs.push_back(v(0,1,0,0,69,  0,0,0,0, 7,1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].rep; j++) begin
        step(vecs[i].rst, vecs[i].valid, vecs[i].det, vecs[i].resync,
             mk(i, j, vecs[i].st, vecs[i].fs, vecs[i].sr, vecs[i].ht, vecs[i].fc, vecs[i].lof));
      end
    end

    // reset mid-frame wins over a simultaneous resync and det
    step(0,1,1,0, mk(100,0, 1,0,0,0, 7,1));
    for (int j = 0; j < 3; j++) step(0,1,0,0, mk(101,j, 1,0,0,0, 7,1));
    step(1,1,1,1, mk(102,0, 0,0,0,0, 0,0));
    step(0,0,0,0, mk(103,0, 0,0,0,0, 0,0));
    step(0,1,1,0, mk(104,0, 1,0,0,0, 0,0));

    valid_in = 1'b0; det_in = 1'b0; resync_in = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
